// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: state encoding, reset PC, step and bubble.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DISCARD
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEF  = 32'd4;
    localparam logic [31:0] NOP          = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, next-PC select and imem handshake.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        mem_stall_i,
    input  logic        PCWrite_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        IF_IDflush_o
);

    fetch_state_e state_q, state_n, done_n;
    logic [31:0]  pc_q, pc_n;
    logic [31:0]  addr_q;
    logic [31:0]  buf_q, buf_n;
    logic [31:0]  last_pc_q, last_instr_q;
    logic         last_valid_q;
    logic         valid_c, req_c;
    logic [31:0]  instr_c;

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        buf_n   = buf_q;
        valid_c = 1'b0;
        req_c   = 1'b0;
        instr_c = NOP;
        done_n  = start_i ? S_FETCH : S_IDLE;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_n = S_FETCH;
            end
            S_FETCH: begin
                req_c = 1'b1;
                if (imem_ack_i) begin
                    valid_c = 1'b1;
                    instr_c = imem_data_i;
                    if (PCWrite_i) begin
                        pc_n    = pc_q + PC_STEP;
                        state_n = done_n;
                    end else begin
                        buf_n   = imem_data_i;
                        state_n = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                valid_c = 1'b1;
                instr_c = buf_q;
                if (PCWrite_i) begin
                    pc_n    = pc_q + PC_STEP;
                    state_n = done_n;
                end
            end
            S_DISCARD: begin
                req_c = 1'b1;
                if (imem_ack_i) state_n = done_n;
            end
            default: state_n = S_IDLE;
        endcase
        // A redirect kills whatever this cycle would have presented.
        if (branch_taken_i) begin
            valid_c = 1'b0;
            instr_c = NOP;
            pc_n    = branch_target_i;
            buf_n   = buf_q;
            if (state_q == S_FETCH)
                state_n = imem_ack_i ? done_n : S_DISCARD;
            else if (state_q == S_HOLD)
                state_n = done_n;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            buf_q        <= NOP;
            last_pc_q    <= '0;
            last_instr_q <= NOP;
            last_valid_q <= 1'b0;
        end else if (!mem_stall_i) begin
            state_q      <= state_n;
            pc_q         <= pc_n;
            buf_q        <= buf_n;
            addr_q       <= (state_n == S_DISCARD) ? addr_q : pc_n;
            last_pc_q    <= pc_q;
            last_instr_q <= instr_c;
            last_valid_q <= valid_c;
        end
    end

    // Stalled cycles replay the last presentation so IF/ID just holds.
    assign imem_req_o    = rst_i & req_c;
    assign imem_addr_o   = rst_i ? addr_q : '0;
    assign pc_o          = !rst_i ? '0 :
                           (mem_stall_i ? last_pc_q : pc_q);
    assign instr_o       = !rst_i ? NOP :
                           (mem_stall_i ? last_instr_q : instr_c);
    assign instr_valid_o = rst_i &
                           (mem_stall_i ? last_valid_q : valid_c);
    assign IF_IDflush_o  = rst_i & ~mem_stall_i &
                           (~valid_c | branch_taken_i);

endmodule
